// File: rtl/alu_seq_if.sv
// Issue/response bundle between Decode/hazard logic and the execute-stage ALU.
// The master drives operands and control; the slave returns ready/valid and the result.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             startE;
  logic [4:0]       opE;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic [WIDTH-1:0] accIn;
  logic             shifterCarryIn;
  logic [3:0]       flagsIn;
  logic             setFlagsE;
  logic             flush;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flags;
  logic             doNotWriteReg;

  modport master (
    output startE, opE, aIn, bIn, accIn, shifterCarryIn, flagsIn, setFlagsE, flush,
    input  ready, valid, Result, Flags, doNotWriteReg
  );

  modport slave (
    input  startE, opE, aIn, bIn, accIn, shifterCarryIn, flagsIn, setFlagsE, flush,
    output ready, valid, Result, Flags, doNotWriteReg
  );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU: 16 ARM data-processing ops in one cycle, MUL/MLA iterative at
// BITS_PER_CYCLE bits per clock; ready drops while a multiply is in flight.
module alu_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);
  localparam int M    = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       fin_q, fin_d;
  logic [3:0]       flags_q, flags_d;
  logic             sflag_q, sflag_d;
  logic             dnw_q, dnw_d;

  logic             ready;
  logic             issue;
  logic             is_mul;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] acc_nxt;

  logic [3:0]       code;
  logic             rev, sub, arith, cin, c_o, v_o;
  logic [WIDTH-1:0] op_a, op_b, op_bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_dnw;

  assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign is_mul = bus.opE[4] && (bus.opE[3:1] == 3'b000);
  assign issue  = ready && bus.startE && !bus.flush;

  // Single-cycle datapath: operand swap/invert feeding one WIDTH+1 adder.
  always_comb begin
    code  = bus.opE[3:0];
    rev   = (code == 4'd3) || (code == 4'd7);
    op_a  = rev ? bus.bIn : bus.aIn;
    op_b  = rev ? bus.aIn : bus.bIn;
    sub   = code inside {4'd2, 4'd3, 4'd6, 4'd7, 4'd10};
    arith = sub || (code inside {4'd4, 4'd5, 4'd11});
    cin   = 1'b0;
    if (code inside {4'd2, 4'd3, 4'd10})
      cin = 1'b1;
    else if (code inside {4'd5, 4'd6, 4'd7})
      cin = bus.flagsIn[1];
    op_bx = sub ? ~op_b : op_b;
    sum   = {1'b0, op_a} + {1'b0, op_bx} + {{WIDTH{1'b0}}, cin};

    case (code)
      4'd0, 4'd8: alu_res = bus.aIn & bus.bIn;
      4'd1, 4'd9: alu_res = bus.aIn ^ bus.bIn;
      4'd12:      alu_res = bus.aIn | bus.bIn;
      4'd13:      alu_res = bus.bIn;
      4'd14:      alu_res = bus.aIn & ~bus.bIn;
      4'd15:      alu_res = ~bus.bIn;
      default:    alu_res = sum[WIDTH-1:0];
    endcase

    if (arith) begin
      c_o = sum[WIDTH];
      v_o = sub ? ((op_a[M] ^ op_b[M]) & (op_a[M] ^ sum[M]))
                : (~(op_a[M] ^ op_b[M]) & (op_a[M] ^ sum[M]));
    end else begin
      c_o = bus.shifterCarryIn;
      v_o = bus.flagsIn[0];
    end

    alu_flags = bus.setFlagsE ? {alu_res[M], (alu_res == '0), c_o, v_o} : bus.flagsIn;
    alu_dnw   = code inside {4'd8, 4'd9, 4'd10, 4'd11};

    // MUL/MLA never take this path, so any bit4 code seen here is reserved.
    if (bus.opE[4]) begin
      alu_res   = '0;
      alu_flags = bus.flagsIn;
      alu_dnw   = 1'b1;
    end
  end

  always_comb begin
    pp = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      if (mplier_q[i]) pp = pp + (mcand_q << i);
    acc_nxt = acc_q + pp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.startE) state_d = is_mul ? S_MUL : S_DONE;
          else            state_d = S_IDLE;
        end
        S_MUL:   if (cnt_q == CW'(1)) state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Multiplicand shifts left each step instead of tracking a separate shift amount.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    res_d    = res_q;
    fin_d    = fin_q;
    flags_d  = flags_q;
    sflag_d  = sflag_q;
    dnw_d    = dnw_q;
    if (bus.flush) begin
      cnt_d = '0;
    end else if (issue) begin
      fin_d   = bus.flagsIn;
      sflag_d = bus.setFlagsE;
      if (is_mul) begin
        mcand_d  = bus.aIn;
        mplier_d = bus.bIn;
        acc_d    = bus.opE[0] ? bus.accIn : '0;
        cnt_d    = CW'(ITER);
      end else begin
        res_d   = alu_res;
        flags_d = alu_flags;
        dnw_d   = alu_dnw;
      end
    end else if (state_q == S_MUL) begin
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
      acc_d    = acc_nxt;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        res_d   = acc_nxt;
        flags_d = sflag_q ? {acc_nxt[M], (acc_nxt == '0), fin_q[1:0]} : fin_q;
        dnw_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      fin_q    <= '0;
      flags_q  <= '0;
      sflag_q  <= 1'b0;
      dnw_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      fin_q    <= fin_d;
      flags_q  <= flags_d;
      sflag_q  <= sflag_d;
      dnw_q    <= dnw_d;
    end
  end

  assign bus.ready         = ready;
  assign bus.valid         = (state_q == S_DONE);
  assign bus.Result        = res_q;
  assign bus.Flags         = flags_q;
  assign bus.doNotWriteReg = dnw_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq: a driver pushes reference-model results into a
// scoreboard; a negedge monitor pops them when valid rises and also tracks expected ready.
module tb_alu_seq;
  localparam int W   = 32;
  localparam int BPC = 2;
  localparam longint MOD  = 64'sd1 <<< W;
  localparam longint HALF = MOD / 2;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         dnw;
    int           cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   busy_last = -1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic longint sx(input logic [W-1:0] x);
    return x[W-1] ? longint'(x) - MOD : longint'(x);
  endfunction

  // ARM semantics in plain integer arithmetic: C is unsigned carry / no-borrow, V is signed range.
  function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, b, acc,
                                 input logic sc, input logic [3:0] fi, input logic s);
    exp_t   e;
    longint ua, ub, ci, r, sr;
    logic   c, v, add, subt;
    ua = longint'(a); ub = longint'(b); ci = longint'(fi[1]);
    r = 0; sr = 0; c = sc; v = fi[0]; add = 1'b0; subt = 1'b0;
    e.cyc = 0;
    e.dnw = (op >= 5'd8 && op <= 5'd11);
    case (op)
      5'd0, 5'd8:  r = ua & ub;
      5'd1, 5'd9:  r = ua ^ ub;
      5'd12:       r = ua | ub;
      5'd13:       r = ub;
      5'd14:       r = ua & ~ub;
      5'd15:       r = ~ub;
      5'd4, 5'd11: begin r = ua + ub;      sr = sx(a) + sx(b);      add = 1'b1; end
      5'd5:        begin r = ua + ub + ci; sr = sx(a) + sx(b) + ci; add = 1'b1; end
      5'd2, 5'd10: begin r = ua - ub;            sr = sx(a) - sx(b);            subt = 1'b1; end
      5'd6:        begin r = ua - ub - (1 - ci); sr = sx(a) - sx(b) - (1 - ci); subt = 1'b1; end
      5'd3:        begin r = ub - ua;            sr = sx(b) - sx(a);            subt = 1'b1; end
      5'd7:        begin r = ub - ua - (1 - ci); sr = sx(b) - sx(a) - (1 - ci); subt = 1'b1; end
      5'd16, 5'd17: begin
        r = ua * ub + ((op == 5'd17) ? longint'(acc) : 64'sd0);
        c = fi[1];
      end
      default: begin
        e.res = '0; e.flags = fi; e.dnw = 1'b1;
        return e;
      end
    endcase
    if (add)  c = (r >= MOD);
    if (subt) c = (r >= 0);
    if (add || subt) v = (sr >= HALF) || (sr < -HALF);
    e.res   = r[W-1:0];
    e.flags = s ? {e.res[W-1], (e.res == '0), c, v} : fi;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      4:       v = W'($urandom_range(0, 15));
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Holds startE with the new op while busy (must be ignored), pushes the expectation at acceptance.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, b, acc,
                       input logic sc, input logic [3:0] fi, input logic s);
    int   guard;
    exp_t e;
    logic mul;
    guard = 0;
    bus.startE = 1'b1; bus.opE = op; bus.aIn = a; bus.bIn = b; bus.accIn = acc;
    bus.shifterCarryIn = sc; bus.flagsIn = fi; bus.setFlagsE = s; bus.flush = 1'b0;
    while (cyc <= busy_last) begin
      step();
      guard++;
      if (guard > 4 * W) begin
        checks++; errors++;
        $display("FAIL issue_wait cyc=%0d busy_last=%0d", cyc, busy_last);
        bus.startE = 1'b0;
        return;
      end
    end
    mul   = (op == 5'd16) || (op == 5'd17);
    e     = model(op, a, b, acc, sc, fi, s);
    e.cyc = cyc + 1 + (mul ? W / BPC : 0);
    if (mul) busy_last = cyc + W / BPC;
    sb.push_back(e);
    step();
    bus.startE = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.startE = 1'b0;
    bus.flush  = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.opE = 5'($urandom); bus.aIn = rnd_val(); bus.bIn = rnd_val(); bus.accIn = rnd_val();
      bus.flagsIn = 4'($urandom); bus.shifterCarryIn = 1'($urandom); bus.setFlagsE = 1'($urandom);
      step();
    end
  endtask

  task automatic flush_now(input logic with_start);
    bus.flush  = 1'b1;
    bus.startE = with_start;
    bus.opE    = 5'd4;
    sb.delete();
    busy_last  = cyc;
    step();
    bus.flush  = 1'b0;
    bus.startE = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (bus.ready !== (cyc > busy_last)) begin
      errors++;
      $display("FAIL ready cyc=%0d got %b want %b", cyc, bus.ready, (cyc > busy_last));
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL missing_valid cyc=%0d want valid at %0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (bus.valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d Result=%h", cyc, bus.Result);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || bus.Result !== e.res || bus.Flags !== e.flags ||
            bus.doNotWriteReg !== e.dnw) begin
          errors++;
          $display("FAIL result cyc=%0d got res=%h nzcv=%b dnw=%b want cyc=%0d res=%h nzcv=%b dnw=%b",
                   cyc, bus.Result, bus.Flags, bus.doNotWriteReg, e.cyc, e.res, e.flags, e.dnw);
        end
      end
    end
  end

  initial begin
    bus.startE = 1'b0; bus.opE = '0; bus.aIn = '0; bus.bIn = '0; bus.accIn = '0;
    bus.shifterCarryIn = 1'b0; bus.flagsIn = '0; bus.setFlagsE = 1'b0; bus.flush = 1'b0;
    step(); step();
    chk("rst_ready",  64'(bus.ready), 64'd1);
    chk("rst_valid",  64'(bus.valid), 64'd0);
    chk("rst_result", 64'(bus.Result), 64'd0);
    chk("rst_flags",  64'(bus.Flags), 64'd0);
    chk("rst_dnw",    64'(bus.doNotWriteReg), 64'd0);
    reset = 1'b1;
    step();

    issue(5'd4,  32'h7FFF_FFFF, 32'd1, '0, 1'b0, 4'b0000, 1'b1);
    idle(1);
    issue(5'd6,  32'd0, 32'd0, '0, 1'b0, 4'b0000, 1'b1);
    issue(5'd3,  32'd5, 32'd3, '0, 1'b0, 4'b0000, 1'b1);
    issue(5'd10, 32'h1234, 32'h1234, '0, 1'b0, 4'b0000, 1'b1);
    issue(5'd13, 32'hDEAD_BEEF, 32'h0, '0, 1'b1, 4'b0001, 1'b1);
    issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 1'b0, 4'b0011, 1'b1);
    idle(2);

    issue(5'd4,  32'd10, 32'd20, '0, 1'b0, 4'b0000, 1'b1);
    issue(5'd16, 32'd1234, 32'd5678, '0, 1'b0, 4'b0110, 1'b1);
    issue(5'd0,  32'h0000_F0F0, 32'h0000_FF00, '0, 1'b1, 4'b0001, 1'b1);
    idle(2);

    issue(5'd16, 32'd7, 32'd9, '0, 1'b0, 4'b0000, 1'b1);
    idle(3);
    flush_now(1'b1);
    idle(4);

    issue(5'd16, 32'd3, 32'd3, '0, 1'b0, 4'b0000, 1'b1);
    idle(2);
    reset = 1'b0;
    #1;
    sb.delete();
    busy_last = cyc;
    chk("arst_result", 64'(bus.Result), 64'd0);
    chk("arst_flags",  64'(bus.Flags), 64'd0);
    chk("arst_valid",  64'(bus.valid), 64'd0);
    chk("arst_dnw",    64'(bus.doNotWriteReg), 64'd0);
    chk("arst_ready",  64'(bus.ready), 64'd1);
    step(); step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [4:0]  op;
      r = $urandom_range(0, 99);
      if (r < 65)      op = 5'($urandom_range(0, 15));
      else if (r < 85) op = 5'($urandom_range(16, 17));
      else             op = 5'($urandom_range(18, 31));
      issue(op, rnd_val(), rnd_val(), rnd_val(), 1'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) begin
        idle($urandom_range(0, 8));
        flush_now(1'($urandom));
      end
    end

    idle(W + 4);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
